concat_rdma: RTL and testbench
==============================

Name: concat_rdma

Overview:
Read DMA that feeds the concat write-back path. On start it fetches two source feature maps (source 0, then source 1) from external memory through the MCIF read port, one Tout-channel surface at a time, in AXI-burst-sized chunks. Returned beats are buffered in a local FIFO and streamed downstream in request order. Downstream stalls never block the read-response port.

Parameters:
TOUT, 32, channels per beat
DAT_DW, 8, bits per channel element; beat width = TOUT*DAT_DW, pixel bytes PB = TOUT*DAT_DW/8
LOG2_W, 16, width of w_in
LOG2_CH, 12, width of channel-group counts
LOG2_BURST, 4, log2 of max burst beats (BURST = 16)
FIFO_DEPTH, 64, response buffer depth in beats; must be >= BURST, power of two

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a transfer when idle
w_in  in  LOG2_W  pixels per surface minus 1
ch0_div_Tout  in  LOG2_CH  source-0 channel groups, >= 1
ch1_div_Tout  in  LOG2_CH  source-1 channel groups, 0 = skip
src0_base_addr, src1_base_addr  in  32  byte base addresses
src0_surface_stride, src1_surface_stride  in  26  byte stride between channel groups
rdma_done  out  1  one-cycle pulse after last beat accepted downstream
rd_req_vld  out  1  read command valid
rd_req_rdy  in  1  read command ready
rd_req_pd  out  LOG2_BURST+32  {len, addr}; len = beats-1
rd_rsp_vld  in  1  read data valid
rd_rsp_rdy  out  1  read data ready
rd_rsp_pd  in  TOUT*DAT_DW  read data beat
dat_out_vld  out  1  downstream valid
dat_out_rdy  in  1  downstream ready
dat_out_pd  out  TOUT*DAT_DW  downstream beat

Behaviour:
- Reset: all outputs 0 except rd_rsp_rdy=1; FSM IDLE, counters, credit and FIFO cleared. Reset mid-transfer drops everything; no recovery of in-flight beats.
- FSM: IDLE --start--> REQ; REQ --last command accepted--> DRAIN; DRAIN --last beat popped--> IDLE with rdma_done pulse. start outside IDLE ignored.
- Command loop (REQ): src_sel (0 then 1) > ch_cnt (0..chN-1) > burst_cnt (0..w_in>>LOG2_BURST). Source 1 skipped when ch1_div_Tout=0.
- len = w_in[LOG2_BURST-1:0] on last burst of a surface, else BURST-1. Last burst with w_in low bits all-ones is a full burst.
- addr = base[src] + ch_cnt*stride[src] + burst_cnt*BURST*PB, 32-bit wrap; stride/bias accumulated incrementally, no multipliers.
- Credit: reserved = beats requested and not yet popped downstream. rd_req_vld = REQ & (reserved + len + 1 <= FIFO_DEPTH). On accept, reserved += len+1; on each dat_out handshake reserved -= 1; both in the same cycle apply net.
- rd_req_vld, once high, holds with stable pd until rd_req_rdy.
- rd_rsp_rdy = 1 always (credit guarantees space). An overflow write is an assertion failure.
- FIFO: first-word-fall-through. dat_out_vld = !empty; simultaneous push/pop at full or empty is legal.
- Latency: a response beat is visible on dat_out one cycle after its rd_rsp handshake.
- Output order equals command order; the block does not reorder responses.

Test Plan:
- Basic: w_in=31, ch0=1, ch1=0, base0=0x1000 -> 2 commands {15,0x1000},{15,0x1200}; 32 beats out in order; one rdma_done.
- Partial burst: w_in=20, ch0=2, stride0=0x400, base0=0 -> commands len 15@0x0, len 4@0x200, len 15@0x400, len 4@0x600; 42 beats out.
- Two sources: ch0=1, ch1=2, w_in=15, base1=0x8000, stride1=0x100 -> commands @base0, then 0x8000, 0x8100; beats from source 0 precede source 1.
- Backpressure: dat_out_rdy=0 for 200 cycles, FIFO_DEPTH=64, w_in=255 -> exactly 4 commands issued, then rd_req_vld low; resumes as beats drain; no data loss.
- Start while busy plus random rd_req_rdy/dat_out_rdy -> second start ignored; beat count and data match the reference model.
- Reset mid-transfer -> all outputs at reset values next cycle; a new start then completes normally.

Source files
------------

// File: rtl/concat_rdma_if.sv
// Bundle of the three handshake channels of the concat read DMA:
//   rd_req  : read command to MCIF  ({len, addr}, len = beats-1)
//   rd_rsp  : read data returned by MCIF
//   dat_out : beat stream towards the concat write-back path
// modport master is the DMA side, modport slave is the memory/downstream side.
interface concat_rdma_if #(
    parameter int TOUT       = 32,
    parameter int DAT_DW     = 8,
    parameter int LOG2_BURST = 4
);
    logic                       rd_req_vld;
    logic                       rd_req_rdy;
    logic [LOG2_BURST+31:0]     rd_req_pd;
    logic                       rd_rsp_vld;
    logic                       rd_rsp_rdy;
    logic [TOUT*DAT_DW-1:0]     rd_rsp_pd;
    logic                       dat_out_vld;
    logic                       dat_out_rdy;
    logic [TOUT*DAT_DW-1:0]     dat_out_pd;

    modport master (
        output rd_req_vld, rd_req_pd,
        input  rd_req_rdy,
        input  rd_rsp_vld, rd_rsp_pd,
        output rd_rsp_rdy,
        output dat_out_vld, dat_out_pd,
        input  dat_out_rdy
    );

    modport slave (
        input  rd_req_vld, rd_req_pd,
        output rd_req_rdy,
        output rd_rsp_vld, rd_rsp_pd,
        input  rd_rsp_rdy,
        input  dat_out_vld, dat_out_pd,
        output dat_out_rdy
    );
endinterface

// File: rtl/concat_rdma.sv
// Read DMA for the concat write-back path.
// On start, fetches source 0 then source 1 (skipped when ch1_div_Tout = 0),
// one Tout-channel surface at a time, in bursts of up to BURST beats. Returned
// beats land in a local first-word-fall-through buffer and stream out in
// command order. A credit counter (beats requested but not yet popped) keeps
// the buffer from overflowing, so the read-response port is always ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, honoured only when idle
//   w_in                  pixels per surface minus 1
//   ch0/ch1_div_Tout      channel groups per source (ch1 = 0 skips source 1)
//   src*_base_addr        byte base address per source
//   src*_surface_stride   byte stride between channel groups per source
//   rdma_done             one-cycle pulse after the last beat leaves
//   bus                   rd_req / rd_rsp / dat_out channels (master side)
module concat_rdma #(
    parameter int TOUT       = 32,
    parameter int DAT_DW     = 8,
    parameter int LOG2_W     = 16,
    parameter int LOG2_CH    = 12,
    parameter int LOG2_BURST = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LOG2_W-1:0]    w_in,
    input  logic [LOG2_CH-1:0]   ch0_div_Tout,
    input  logic [LOG2_CH-1:0]   ch1_div_Tout,
    input  logic [31:0]          src0_base_addr,
    input  logic [31:0]          src1_base_addr,
    input  logic [25:0]          src0_surface_stride,
    input  logic [25:0]          src1_surface_stride,
    output logic                 rdma_done,
    concat_rdma_if.master        bus
);
    localparam int DW    = TOUT * DAT_DW;
    localparam int PB    = DW / 8;
    localparam int BURST = 1 << LOG2_BURST;
    localparam int BC_W  = LOG2_W - LOG2_BURST;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [31:0]        BURST_BYTES = 32'(BURST * PB);
    localparam logic [LOG2_CH-1:0] CH_ONE      = LOG2_CH'(1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t               state_reg, state_next;

    // Transfer parameters captured at start
    logic [LOG2_W-1:0]    w_reg;
    logic [LOG2_CH-1:0]   ch0_reg, ch1_reg;
    logic [31:0]          base1_reg;
    logic [25:0]          stride0_reg, stride1_reg;

    // Command loop state; surf_base = base + ch*stride, burst_bias = burst*BURST*PB
    logic                 src_sel_reg;
    logic [LOG2_CH-1:0]   ch_cnt_reg;
    logic [BC_W-1:0]      burst_cnt_reg;
    logic [31:0]          surf_base_reg;
    logic [31:0]          burst_bias_reg;

    logic [CW-1:0]        reserved_reg, reserved_next;
    logic                 done_reg;

    // Response buffer: array plus an output register that holds the head beat
    logic [DW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        mem_cnt_reg;
    logic                 out_vld_reg;
    logic [DW-1:0]        out_pd_reg;

    logic                 last_burst, last_ch, last_cmd;
    logic [LOG2_CH-1:0]   ch_lim;
    logic [LOG2_BURST-1:0] cmd_len;
    logic [CW-1:0]        beats_req;
    logic [CW:0]          credit_sum;
    logic                 req_vld, accept, pop, push;
    logic                 load, mem_empty, mem_full, mem_push, mem_pop;

    // ---------------- command generation ----------------
    always_comb begin
        last_burst = (burst_cnt_reg == w_reg[LOG2_W-1:LOG2_BURST]);
        // Last burst of a surface carries the remainder; all-ones remainder is a full burst
        cmd_len    = last_burst ? w_reg[LOG2_BURST-1:0] : {LOG2_BURST{1'b1}};
        ch_lim     = src_sel_reg ? ch1_reg : ch0_reg;
        last_ch    = (ch_cnt_reg == ch_lim - CH_ONE);
        last_cmd   = last_burst && last_ch && (src_sel_reg || (ch1_reg == '0));
        beats_req  = CW'(cmd_len) + CW'(1);
        credit_sum = (CW+1)'(reserved_reg) + (CW+1)'(beats_req);
        req_vld    = (state_reg == REQ) && (credit_sum <= (CW+1)'(FIFO_DEPTH));
        accept     = req_vld && bus.rd_req_rdy;
        pop        = out_vld_reg && bus.dat_out_rdy;
        push       = bus.rd_rsp_vld;
    end

    // Credit can only shrink while a command waits, so a raised request stays raised
    always_comb begin
        reserved_next = reserved_reg
                      + (accept ? beats_req : '0)
                      - (pop ? CW'(1) : '0);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)                          state_next = REQ;
            REQ:     if (accept && last_cmd)             state_next = DRAIN;
            DRAIN:   if (pop && reserved_reg == CW'(1))  state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_req_vld  = req_vld;
        bus.rd_req_pd   = req_vld ? {cmd_len, surf_base_reg + burst_bias_reg} : '0;
        bus.rd_rsp_rdy  = 1'b1;
        bus.dat_out_vld = out_vld_reg;
        bus.dat_out_pd  = out_pd_reg;
        rdma_done       = done_reg;
    end

    // ---------------- loop counters and credit ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg          <= '0;
            ch0_reg        <= '0;
            ch1_reg        <= '0;
            base1_reg      <= '0;
            stride0_reg    <= '0;
            stride1_reg    <= '0;
            src_sel_reg    <= 1'b0;
            ch_cnt_reg     <= '0;
            burst_cnt_reg  <= '0;
            surf_base_reg  <= '0;
            burst_bias_reg <= '0;
            reserved_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            reserved_reg <= reserved_next;
            done_reg     <= (state_reg == DRAIN) && (state_next == IDLE);
            if (state_reg == IDLE && start) begin
                w_reg          <= w_in;
                ch0_reg        <= ch0_div_Tout;
                ch1_reg        <= ch1_div_Tout;
                base1_reg      <= src1_base_addr;
                stride0_reg    <= src0_surface_stride;
                stride1_reg    <= src1_surface_stride;
                src_sel_reg    <= 1'b0;
                ch_cnt_reg     <= '0;
                burst_cnt_reg  <= '0;
                surf_base_reg  <= src0_base_addr;
                burst_bias_reg <= '0;
            end else if (accept) begin
                if (!last_burst) begin
                    burst_cnt_reg  <= burst_cnt_reg + BC_W'(1);
                    burst_bias_reg <= burst_bias_reg + BURST_BYTES;
                end else begin
                    burst_cnt_reg  <= '0;
                    burst_bias_reg <= '0;
                    if (!last_ch) begin
                        ch_cnt_reg    <= ch_cnt_reg + CH_ONE;
                        surf_base_reg <= surf_base_reg +
                                         {6'd0, (src_sel_reg ? stride1_reg : stride0_reg)};
                    end else if (!src_sel_reg) begin
                        // Harmless after the final command: the FSM has left REQ
                        src_sel_reg   <= 1'b1;
                        ch_cnt_reg    <= '0;
                        surf_base_reg <= base1_reg;
                    end
                end
            end
        end
    end

    // ---------------- response buffer ----------------
    // The output register is refilled whenever it is empty or being popped;
    // with nothing stored, an arriving beat bypasses the array so it shows up
    // on dat_out the cycle after its handshake.
    always_comb begin
        mem_empty = (mem_cnt_reg == '0);
        mem_full  = (mem_cnt_reg == CW'(FIFO_DEPTH));
        load      = !out_vld_reg || pop;
        mem_pop   = load && !mem_empty;
        mem_push  = push && !(load && mem_empty);
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem[wr_ptr_reg] <= bus.rd_rsp_pd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            mem_cnt_reg <= '0;
            out_vld_reg <= 1'b0;
            out_pd_reg  <= '0;
        end else begin
            if (mem_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (mem_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            mem_cnt_reg <= mem_cnt_reg + (mem_push ? CW'(1) : '0) - (mem_pop ? CW'(1) : '0);
            if (load) begin
                out_vld_reg <= !mem_empty || push;
                if (!mem_empty) begin
                    out_pd_reg <= mem[rd_ptr_reg];
                end else if (push) begin
                    out_pd_reg <= bus.rd_rsp_pd;
                end
            end
        end
    end

    // Credit accounting must make this unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_push && !mem_pop && mem_full));

endmodule

// File: tb/tb_concat_rdma.sv
module tb_concat_rdma;
    localparam int TOUT = 32, DAT_DW = 8, LOG2_W = 16, LOG2_CH = 12;
    localparam int LOG2_BURST = 4, FIFO_DEPTH = 64;
    localparam int DW = TOUT * DAT_DW;
    localparam int PB = DW / 8;

    typedef struct {
        logic [3:0]  len;
        logic [31:0] addr;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n, start, rdma_done;
    logic [15:0] w_in;
    logic [11:0] ch0_div_Tout, ch1_div_Tout;
    logic [31:0] src0_base_addr, src1_base_addr;
    logic [25:0] src0_surface_stride, src1_surface_stride;

    always #5 clk = ~clk;

    concat_rdma_if #(.TOUT(TOUT), .DAT_DW(DAT_DW), .LOG2_BURST(LOG2_BURST)) bus ();

    concat_rdma #(
        .TOUT(TOUT), .DAT_DW(DAT_DW), .LOG2_W(LOG2_W), .LOG2_CH(LOG2_CH),
        .LOG2_BURST(LOG2_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .w_in(w_in),
        .ch0_div_Tout(ch0_div_Tout), .ch1_div_Tout(ch1_div_Tout),
        .src0_base_addr(src0_base_addr), .src1_base_addr(src1_base_addr),
        .src0_surface_stride(src0_surface_stride), .src1_surface_stride(src1_surface_stride),
        .rdma_done(rdma_done), .bus(bus)
    );

    int checks = 0, errors = 0, xfer_no = 0;
    cmd_t exp_cmds[$];
    cmd_t log_cmds[$];
    logic [DW-1:0] rsp_q[$];     // beats the memory model still owes
    logic [DW-1:0] model_q[$];   // beats that must be visible downstream
    int  cmd_idx, popped, exp_total, resv;
    bit  exp_done, done_seen, prev_stall;
    logic [35:0] prev_pd;
    int  p_req = 100, p_out = 100, p_rsp = 100;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [31:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(i) * 32'h0100_0193) ^ 32'hC0DE_0000;
        return d;
    endfunction

    // Expected command list straight from the loop nest, with multiplications
    task automatic build_cmds();
        cmd_t c;
        int nb;
        exp_cmds.delete();
        exp_total = 0;
        nb = int'(w_in >> 4);
        for (int s = 0; s < 2; s++) begin
            int nch;
            nch = (s == 0) ? int'(ch0_div_Tout) : int'(ch1_div_Tout);
            for (int ch = 0; ch < nch; ch++) begin
                for (int b = 0; b <= nb; b++) begin
                    c.len  = (b == nb) ? w_in[3:0] : 4'hF;
                    c.addr = ((s == 0) ? src0_base_addr : src1_base_addr)
                           + 32'(ch) * 32'((s == 0) ? src0_surface_stride : src1_surface_stride)
                           + 32'(b) * 32'(16 * PB);
                    exp_cmds.push_back(c);
                    exp_total += int'(c.len) + 1;
                end
            end
        end
    endtask

    // One clock: compare outputs at the falling edge, drive new inputs,
    // then account for the handshakes the next rising edge will perform.
    task automatic cycle();
        logic [35:0] pd;
        cmd_t c;
        @(negedge clk);
        pd = bus.rd_req_pd;
        if (rst_n) begin
            chk("dat_out_vld", DW'(bus.dat_out_vld), DW'(model_q.size() != 0));
            if (model_q.size() != 0) chk("dat_out_pd", bus.dat_out_pd, model_q[0]);
            chk("rdma_done", DW'(rdma_done), DW'(exp_done));
            chk("rd_rsp_rdy", DW'(bus.rd_rsp_rdy), DW'(1'b1));
            if (prev_stall) begin
                chk("req_hold_vld", DW'(bus.rd_req_vld), DW'(1'b1));
                chk("req_hold_pd", DW'(pd), DW'(prev_pd));
            end
            if (rdma_done) done_seen = 1;
        end
        exp_done = 0;
        bus.rd_req_rdy  = ($urandom_range(99) < p_req);
        bus.dat_out_rdy = ($urandom_range(99) < p_out);
        if (rsp_q.size() != 0 && $urandom_range(99) < p_rsp) begin
            bus.rd_rsp_vld = 1'b1;
            bus.rd_rsp_pd  = rsp_q[0];
        end else begin
            bus.rd_rsp_vld = 1'b0;
            bus.rd_rsp_pd  = '0;
        end
        if (!rst_n) begin
            prev_stall = 0;
            return;
        end
        if (bus.rd_req_vld && bus.rd_req_rdy) begin
            c.len  = pd[35:32];
            c.addr = pd[31:0];
            if (cmd_idx < exp_cmds.size()) begin
                chk("cmd_len", DW'(c.len), DW'(exp_cmds[cmd_idx].len));
                chk("cmd_addr", DW'(c.addr), DW'(exp_cmds[cmd_idx].addr));
            end else begin
                checks++;
                errors++;
                $display("FAIL cmd_extra actual=%0h required=none", pd);
            end
            chk("credit", DW'(resv + int'(c.len) + 1 <= FIFO_DEPTH), DW'(1'b1));
            resv += int'(c.len) + 1;
            cmd_idx++;
            log_cmds.push_back(c);
            for (int i = 0; i <= int'(c.len); i++)
                rsp_q.push_back(beat_data(c.addr + 32'(i * PB)));
        end
        prev_stall = bus.rd_req_vld && !bus.rd_req_rdy;
        prev_pd    = pd;
        if (bus.dat_out_vld && bus.dat_out_rdy && model_q.size() != 0) begin
            model_q.delete(0);
            popped++;
            resv--;
            if (popped == exp_total) exp_done = 1;
        end
        if (bus.rd_rsp_vld) begin
            model_q.push_back(bus.rd_rsp_pd);
            rsp_q.delete(0);
        end
    endtask

    task automatic start_xfer(input logic [15:0] w, input logic [11:0] c0, input logic [11:0] c1,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [25:0] s0, input logic [25:0] s1);
        w_in = w; ch0_div_Tout = c0; ch1_div_Tout = c1;
        src0_base_addr = b0; src1_base_addr = b1;
        src0_surface_stride = s0; src1_surface_stride = s1;
        build_cmds();
        cmd_idx = 0; popped = 0; done_seen = 0;
        log_cmds.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_xfer(input int budget, input int restart_at);
        for (int n = 0; n < budget && !done_seen; n++) begin
            if (n == restart_at) start = 1'b1;
            cycle();
            start = 1'b0;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        chk("cmd_count", DW'(cmd_idx), DW'(exp_cmds.size()));
        chk("beat_count", DW'(popped), DW'(exp_total));
        repeat (5) cycle();
        $display("xfer %0d: w_in=%0d ch0=%0d ch1=%0d cmds=%0d beats=%0d",
                 xfer_no, w_in, ch0_div_Tout, ch1_div_Tout, cmd_idx, popped);
        xfer_no++;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_vld", DW'(bus.rd_req_vld), '0);
        chk("rst_req_pd", DW'(bus.rd_req_pd), '0);
        chk("rst_rsp_rdy", DW'(bus.rd_rsp_rdy), DW'(1'b1));
        chk("rst_out_vld", DW'(bus.dat_out_vld), '0);
        chk("rst_out_pd", bus.dat_out_pd, '0);
        chk("rst_done", DW'(rdma_done), '0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        w_in = '0; ch0_div_Tout = '0; ch1_div_Tout = '0;
        src0_base_addr = '0; src1_base_addr = '0;
        src0_surface_stride = '0; src1_surface_stride = '0;
        bus.rd_req_rdy = 1'b0; bus.rd_rsp_vld = 1'b0; bus.rd_rsp_pd = '0; bus.dat_out_rdy = 1'b0;
        cmd_idx = 0; popped = 0; exp_total = 0; resv = 0;
        exp_done = 0; done_seen = 0; prev_stall = 0; prev_pd = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        cycle();

        // Basic: two full bursts
        start_xfer(16'd31, 12'd1, 12'd0, 32'h1000, 32'h0, 26'h0, 26'h0);
        finish_xfer(2000, -1);
        chk("basic_ncmd", DW'(log_cmds.size()), DW'(2));
        chk("basic_len0", DW'(log_cmds[0].len), DW'(4'd15));
        chk("basic_addr0", DW'(log_cmds[0].addr), DW'(32'h1000));
        chk("basic_addr1", DW'(log_cmds[1].addr), DW'(32'h1200));
        chk("basic_beats", DW'(popped), DW'(32));

        // Partial last burst across two channel groups
        start_xfer(16'd20, 12'd2, 12'd0, 32'h0, 32'h0, 26'h400, 26'h0);
        finish_xfer(2000, -1);
        chk("part_len1", DW'(log_cmds[1].len), DW'(4'd4));
        chk("part_addr1", DW'(log_cmds[1].addr), DW'(32'h200));
        chk("part_addr2", DW'(log_cmds[2].addr), DW'(32'h400));
        chk("part_addr3", DW'(log_cmds[3].addr), DW'(32'h600));
        chk("part_beats", DW'(popped), DW'(42));

        // Two sources
        start_xfer(16'd15, 12'd1, 12'd2, 32'h2000, 32'h8000, 26'h40, 26'h100);
        finish_xfer(2000, -1);
        chk("two_addr0", DW'(log_cmds[0].addr), DW'(32'h2000));
        chk("two_addr1", DW'(log_cmds[1].addr), DW'(32'h8000));
        chk("two_addr2", DW'(log_cmds[2].addr), DW'(32'h8100));

        // Backpressure: credit stops requests at 64 outstanding beats
        p_out = 0;
        start_xfer(16'd255, 12'd1, 12'd0, 32'h10000, 32'h0, 26'h0, 26'h0);
        repeat (200) cycle();
        chk("bp_ncmd", DW'(log_cmds.size()), DW'(4));
        chk("bp_req_low", DW'(bus.rd_req_vld), '0);
        p_out = 100;
        finish_xfer(4000, -1);

        // Random handshakes, start while busy, random configurations
        p_req = 60; p_out = 50; p_rsp = 70;
        start_xfer(16'd60, 12'd2, 12'd1, 32'h4000, 32'h9000, 26'h800, 26'h800);
        finish_xfer(20000, 10);
        for (int t = 0; t < 6; t++) begin
            logic [31:0] b0;
            b0 = (t == 0) ? 32'hFFFF_FF00 : ($urandom() & 32'hFFFF_FFE0);
            start_xfer(16'($urandom_range(80)), 12'($urandom_range(1, 3)), 12'($urandom_range(0, 2)),
                       b0, $urandom() & 32'hFFFF_FFE0, 26'($urandom()), 26'($urandom()));
            finish_xfer(20000, -1);
        end

        // Reset in the middle of a transfer
        start_xfer(16'd255, 12'd2, 12'd0, 32'h20000, 32'h0, 26'h1000, 26'h0);
        repeat (30) cycle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_q.delete(); rsp_q.delete();
        resv = 0; exp_done = 0; prev_stall = 0;
        bus.rd_rsp_vld = 1'b0; bus.rd_rsp_pd = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        start_xfer(16'd40, 12'd1, 12'd1, 32'h3000, 32'h7000, 26'h0, 26'h0);
        finish_xfer(20000, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
